spi_register_map: RTL and testbench

// - SPI-slave (mode 0) register map: 12 R/W config regs (addr 0-11), 4 read-only status regs (addr 12-15).
// - Config regs drive the dedicated outputs and a PRBS-7 generator on uio_out[7].
// - SPI pins are asynchronous to clk; they are synchronized and edge-detected in the clk domain.

---
 rtl/spi_register_map.sv | 195 +++++++++++++++++++
 tb/tb_spi_register_map.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_register_map.sv
// SPI mode-0 slave register map: 12 R/W config registers, 4 read-only status
// registers, config-driven outputs and a PRBS-7 generator on uio_out[7].
// SPI pins are asynchronous; they are synchronized and edge-detected on clk.
module spi_register_map #(
  parameter int ADDR_WIDTH     = 7,
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_CONFIG_REG = 12,
  parameter int NUM_STATUS_REG = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  localparam int CFG_IDX_W = $clog2(NUM_CONFIG_REG);
  localparam logic [ADDR_WIDTH-1:0] CFG_END = ADDR_WIDTH'(NUM_CONFIG_REG);
  localparam logic [ADDR_WIDTH-1:0] ADDR_UI = ADDR_WIDTH'(NUM_CONFIG_REG + 2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ID = ADDR_WIDTH'(NUM_CONFIG_REG + NUM_STATUS_REG - 1);
  // bit_cnt_q value seen on the rising edge that completes the command / frame
  localparam logic [4:0] CMD_LAST   = 5'(ADDR_WIDTH);
  localparam logic [4:0] FRAME_LAST = 5'(ADDR_WIDTH + DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_DONE
  } state_e;

  // synchronizers: [1] is the synchronized level, [2] the previous level
  logic [2:0] sck_q;
  logic [1:0] sdi_q;
  logic [2:0] csn_q;
  logic [7:0] ui_meta_q;
  logic [7:0] ui_q;

  logic sck_rise, sck_fall, csn_fall, csn_s, sdi_s;

  state_e                state_q;
  logic [4:0]            bit_cnt_q;
  logic [DATA_WIDTH-2:0] shift_q;
  logic                  rw_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] tx_q;
  logic                  sdo_q;
  logic                  wr_pend_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  logic [DATA_WIDTH-1:0] cfg_q [NUM_CONFIG_REG];
  logic [6:0]            lfsr_q;

  logic [ADDR_WIDTH-1:0] cmd_addr_d;
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic [6:0]            seed_d;
  logic [6:0]            lfsr_d;

  logic unused_ok;
  assign unused_ok = ^{ena, uio_in[7:4], uio_in[2]};

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign csn_s    = csn_q[1];
  assign csn_fall = ~csn_q[1] & csn_q[2];
  assign sdi_s    = sdi_q[1];

  // Synchronize SPI pins and ui_in into the clk domain.
  // CS_N resets to 0 so a reset taken with CS_N low cannot fake a falling
  // edge; a frame only starts on a genuine high-to-low transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q     <= '0;
      sdi_q     <= '0;
      csn_q     <= '0;
      ui_meta_q <= '0;
      ui_q      <= '0;
    end else begin
      sck_q     <= {sck_q[1:0], uio_in[0]};
      sdi_q     <= {sdi_q[0], uio_in[1]};
      csn_q     <= {csn_q[1:0], uio_in[3]};
      ui_meta_q <= ui_in;
      ui_q      <= ui_meta_q;
    end
  end

  // Address being completed on the 8th rising edge and its read data.
  always_comb begin
    cmd_addr_d = {shift_q[ADDR_WIDTH-2:0], sdi_s};
    rd_data_d  = '0;
    if (cmd_addr_d < CFG_END) begin
      rd_data_d = cfg_q[cmd_addr_d[CFG_IDX_W-1:0]];
    end else if (cmd_addr_d == ADDR_UI) begin
      rd_data_d = ui_q;
    end else if (cmd_addr_d == ADDR_ID) begin
      rd_data_d = '1;
    end
  end

  // SPI frame FSM: command capture, read shift-out, write request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      tx_q      <= '0;
      sdo_q     <= 1'b0;
      wr_pend_q <= 1'b0;
      wr_data_q <= '0;
    end else begin
      wr_pend_q <= 1'b0;
      if (csn_s) begin
        state_q   <= S_IDLE;
        bit_cnt_q <= '0;
        shift_q   <= '0;
        tx_q      <= '0;
        sdo_q     <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (csn_fall) state_q <= S_CMD;
          end
          S_CMD: begin
            if (sck_rise) begin
              shift_q   <= {shift_q[DATA_WIDTH-3:0], sdi_s};
              bit_cnt_q <= bit_cnt_q + 5'd1;
              if (bit_cnt_q == CMD_LAST) begin
                rw_q    <= shift_q[ADDR_WIDTH-1];
                addr_q  <= cmd_addr_d;
                tx_q    <= rd_data_d;
                state_q <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (sck_rise) begin
              shift_q   <= {shift_q[DATA_WIDTH-3:0], sdi_s};
              bit_cnt_q <= bit_cnt_q + 5'd1;
              if (bit_cnt_q == FRAME_LAST) begin
                state_q <= S_DONE;
                if (!rw_q) begin
                  wr_pend_q <= 1'b1;
                  wr_data_q <= {shift_q, sdi_s};
                end
              end
            end else if (sck_fall && rw_q) begin
              sdo_q <= tx_q[DATA_WIDTH-1];
              tx_q  <= {tx_q[DATA_WIDTH-2:0], 1'b0};
            end
          end
          S_DONE: begin
            if (sck_fall) sdo_q <= 1'b0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Config register file; writes beyond the config range are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CONFIG_REG; i++) cfg_q[i] <= '0;
    end else if (wr_pend_q && (addr_q < CFG_END)) begin
      cfg_q[addr_q[CFG_IDX_W-1:0]] <= wr_data_q;
    end
  end

  // PRBS-7 seed (all-zero seed would lock up) and next state, x^7+x^6+1.
  always_comb begin
    seed_d = (cfg_q[1][6:0] == 7'h00) ? 7'h7F : cfg_q[1][6:0];
    lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
  end

  // LFSR runs while enabled, otherwise holds the seed so enabling restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 7'h7F;
    end else if (cfg_q[2][7]) begin
      lfsr_q <= lfsr_d;
    end else begin
      lfsr_q <= seed_d;
    end
  end

  assign uio_out = {cfg_q[2][7] & lfsr_q[6], cfg_q[2][6], 3'b000, sdo_q, 2'b00};
  assign uio_oe  = 8'b1100_0100;
  assign uo_out  = cfg_q[3];

endmodule

// File: tb/tb_spi_register_map.sv
// Scoreboard bench for spi_register_map: stimulus pushes expected read data,
// an SPI monitor decodes each completed frame and compares.
`timescale 1ns/1ps
module tb_spi_register_map;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] uo_out;

  logic sck, sdi, cs_n;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [6:0] addr;
    logic [7:0] data;
  } exp_t;
  exp_t expq[$];

  logic [7:0] model [12];
  logic       prbs_s [254];

  assign uio_in = {4'b0000, cs_n, 1'b0, sdi, sck};

  spi_register_map #(
    .ADDR_WIDTH(7),
    .DATA_WIDTH(8),
    .NUM_CONFIG_REG(12),
    .NUM_STATUS_REG(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .ui_in(ui_in),
    .uio_in(uio_in),
    .uio_out(uio_out),
    .uio_oe(uio_oe),
    .uo_out(uo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected read value from the register map rules.
  function automatic logic [7:0] exp_read(input int a);
    if (a < 12) return model[a];
    if (a == 14) return ui_in;
    if (a == 15) return 8'hFF;
    return 8'h00;
  endfunction

  task automatic spi_frame(input logic [23:0] bits, input int nbits, input bit end_cs);
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sdi = bits[23-i];
      repeat (4) @(negedge clk);
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
    repeat (4) @(negedge clk);
    if (end_cs) begin
      cs_n = 1'b1;
      sdi  = 1'b0;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic spi_write(input int a, input logic [7:0] d);
    if (a < 12) model[a] = d;
    spi_frame({1'b0, 7'(a), d, 8'h00}, 16, 1'b1);
  endtask

  task automatic spi_read(input int a);
    exp_t e;
    e.addr = 7'(a);
    e.data = exp_read(a);
    expq.push_back(e);
    spi_frame({1'b1, 7'(a), 8'h00, 8'h00}, 16, 1'b1);
  endtask

  task automatic capture_prbs(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      prbs_s[i] = uio_out[7];
    end
  endtask

  // Monitor: decode every frame on the SPI pins and score full 16-bit frames.
  initial begin : monitor
    logic [15:0] mosi;
    logic [7:0]  miso;
    logic        sdo_early;
    int          n;
    exp_t        e;
    forever begin
      @(negedge cs_n);
      n = 0;
      mosi = '0;
      miso = '0;
      sdo_early = 1'b0;
      while (cs_n == 1'b0) begin
        @(posedge sck or posedge cs_n);
        if (cs_n == 1'b0) begin
          n++;
          mosi = {mosi[14:0], sdi};
          if (n <= 8) sdo_early = sdo_early | uio_out[2];
          else if (n <= 16) miso = {miso[6:0], uio_out[2]};
        end
      end
      if (n == 16) begin
        check("sdo low in command phase", {31'd0, sdo_early}, 32'd0);
        if (mosi[15]) begin
          if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL read without expectation: addr %0d got 0x%0h", mosi[14:8], miso);
          end else begin
            e = expq.pop_front();
            check($sformatf("read addr %0d", e.addr), {24'd0, miso}, {24'd0, e.data});
          end
        end else begin
          check("sdo low on write frame", {24'd0, miso}, 32'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [15:0] first16, again16;
    int          mism, ones, ones32, a;
    logic [7:0]  d;

    rst = 1'b1; ena = 1'b1; ui_in = 8'hFF;
    sck = 1'b0; sdi = 1'b0; cs_n = 1'b1;
    for (int i = 0; i < 12; i++) model[i] = 8'h00;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    check("uo_out after reset", {24'd0, uo_out}, 32'h00);
    check("uio_out after reset", {24'd0, uio_out}, 32'h00);
    check("uio_oe constant", {24'd0, uio_oe}, 32'hC4);

    spi_read(0);
    spi_write(5, 8'hA5);
    spi_read(5);
    spi_write(3, 8'h3C);
    check("uo_out follows cfg3", {24'd0, uo_out}, 32'h3C);

    spi_read(13);
    spi_read(15);
    spi_read(14);
    spi_write(14, 8'h12);
    spi_read(14);
    spi_read(12);

    // PRBS: seed 0x7F, enable off with cfg2[6] set, then enable
    spi_write(1, 8'hFF);
    spi_write(2, 8'h7F);
    check("uio_out[6] = cfg2[6]", {31'd0, uio_out[6]}, 32'd1);
    check("prbs off drives 0", {31'd0, uio_out[7]}, 32'd0);
    spi_write(2, 8'hFF);
    capture_prbs(254);
    mism = 0; ones = 0; ones32 = 0;
    for (int i = 0; i < 127; i++) begin
      if (prbs_s[i] !== prbs_s[i+127]) mism++;
      if (prbs_s[i]) ones++;
      if (i < 32 && prbs_s[i]) ones32++;
    end
    for (int i = 0; i < 16; i++) first16[i] = prbs_s[i];
    check("prbs period 127", mism, 0);
    check("prbs ones per period", ones, 64);
    check("prbs 32 samples vary", {31'd0, (ones32 != 0) && (ones32 != 32)}, 32'd1);

    // disable then enable: sequence restarts from the seed
    spi_write(2, 8'h00);
    spi_write(2, 8'h80);
    check("uio_out[6] cleared", {31'd0, uio_out[6]}, 32'd0);
    capture_prbs(16);
    for (int i = 0; i < 16; i++) again16[i] = prbs_s[i];
    check("prbs restart from seed", {16'd0, again16}, {16'd0, first16});

    // zero seed must still produce a maximal sequence
    spi_write(1, 8'h00);
    spi_write(2, 8'h00);
    spi_write(2, 8'h80);
    capture_prbs(127);
    ones = 0;
    for (int i = 0; i < 127; i++) if (prbs_s[i]) ones++;
    check("prbs zero seed ones", ones, 64);
    spi_write(2, 8'h00);

    // randomized writes then full read-back
    ui_in = 8'($urandom_range(0, 255));
    repeat (4) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      a = $urandom_range(0, 15);
      d = 8'($urandom_range(0, 255));
      spi_write(a, d);
    end
    spi_write(100, 8'h5A);
    for (int k = 0; k < 16; k++) spi_read(k);
    for (int k = 0; k < 3; k++) spi_read($urandom_range(16, 127));
    spi_read(127);

    // extra rising edges past bit 16 are ignored
    spi_frame({1'b0, 7'd4, 8'h81, 8'hF0}, 20, 1'b1);
    model[4] = 8'h81;
    spi_read(4);

    // aborted frame leaves the register unchanged
    spi_write(7, 8'h55);
    spi_frame({1'b0, 7'd7, 8'hAA, 8'h00}, 10, 1'b1);
    spi_read(7);

    // reset in the middle of a frame
    spi_write(3, 8'hC3);
    check("uo_out before mid-frame reset", {24'd0, uo_out}, 32'hC3);
    spi_frame({1'b0, 7'd7, 8'hAA, 8'h00}, 6, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) model[i] = 8'h00;
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    sdi  = 1'b0;
    repeat (8) @(negedge clk);
    check("uo_out after mid-frame reset", {24'd0, uo_out}, 32'h00);
    spi_read(7);
    spi_read(3);
    spi_write(9, 8'h96);
    spi_read(9);

    repeat (20) @(negedge clk);
    check("scoreboard drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
